// File: rtl/rrv64_vec_vrf_rd_xbar_pkg.sv
// Shared geometry and tag definitions for the banked VRF read crossbar.
package rrv64_vec_vrf_rd_xbar_pkg;

  localparam int unsigned VSB_ENT_NUM       = 16;
  localparam int unsigned VRF_RD_TAG_W      = VSB_ENT_NUM + 2;
  localparam int unsigned VRF_RPORT_NUM     = 5;
  localparam int unsigned BANK_X_WIDTH      = 1;
  localparam int unsigned BANK_Y_WIDTH      = 1;
  localparam int unsigned PERBANK_ROW_WIDTH = 4;
  localparam int unsigned VRF_PREBANK_RPORT = 2;
  localparam int unsigned VFULEN            = 256;

  typedef struct packed {
    logic [VSB_ENT_NUM-1:0] rs_idx;
    logic [1:0]             rs_field_idx;
  } vrf_rd_tag_t;

  // Index width that stays legal for single-entry selections.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rrv64_vec_vrf_bank_rr_arb.sv
// Per-bank round-robin arbiter: grants up to BANK_RPORT request groups, slots filled in grant order.
module rrv64_vec_vrf_bank_rr_arb
  import rrv64_vec_vrf_rd_xbar_pkg::*;
#(
  parameter int unsigned RPORT_NUM  = VRF_RPORT_NUM,
  parameter int unsigned BANK_RPORT = VRF_PREBANK_RPORT
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [RPORT_NUM-1:0]                  req_i,
  output logic [BANK_RPORT-1:0][RPORT_NUM-1:0]  slot_gnt_o,
  output logic [BANK_RPORT-1:0]                 slot_vld_o
);

  localparam int unsigned PTR_W  = clog2_min1(RPORT_NUM);
  localparam int unsigned SLOT_W = clog2_min1(BANK_RPORT);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    int idx;
    int cnt;
    slot_gnt_o = '0;
    slot_vld_o = '0;
    rr_ptr_d   = rr_ptr_q;
    cnt        = 0;
    idx        = 0;
    for (int i = 0; i < int'(RPORT_NUM); i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= int'(RPORT_NUM)) idx -= int'(RPORT_NUM);
      if (req_i[PTR_W'(idx)] && (cnt < int'(BANK_RPORT))) begin
        slot_gnt_o[SLOT_W'(cnt)][PTR_W'(idx)] = 1'b1;
        slot_vld_o[SLOT_W'(cnt)]              = 1'b1;
        cnt++;
        // Pointer lands just past the last leader granted this cycle.
        rr_ptr_d = (idx + 1 == int'(RPORT_NUM)) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/rrv64_vec_vrf_rd_xbar.sv
// Banked VRF read crossbar: decodes, coalesces and arbitrates read ports onto bank SRAM ports.
module rrv64_vec_vrf_rd_xbar
  import rrv64_vec_vrf_rd_xbar_pkg::*;
#(
  parameter int unsigned RPORT_NUM  = VRF_RPORT_NUM,
  parameter int unsigned BANK_X_W   = BANK_X_WIDTH,
  parameter int unsigned BANK_Y_W   = BANK_Y_WIDTH,
  parameter int unsigned ROW_W      = PERBANK_ROW_WIDTH,
  parameter int unsigned BANK_RPORT = VRF_PREBANK_RPORT,
  parameter int unsigned DATA_W     = VFULEN,
  parameter int unsigned TAG_W      = VRF_RD_TAG_W,
  localparam int unsigned REG_W     = BANK_Y_W + ROW_W,
  localparam int unsigned ADDR_W    = REG_W + BANK_X_W,
  localparam int unsigned BANK_NUM  = 2 ** (BANK_X_W + BANK_Y_W)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush,
  input  logic [RPORT_NUM-1:0]                    req_vld,
  input  logic [RPORT_NUM*ADDR_W-1:0]             req_vaddr,
  input  logic [RPORT_NUM*TAG_W-1:0]              req_tag,
  output logic [RPORT_NUM-1:0]                    req_rdy,
  output logic [BANK_NUM*BANK_RPORT-1:0]          bank_rd_en,
  output logic [BANK_NUM*BANK_RPORT*ROW_W-1:0]    bank_rd_row,
  input  logic [BANK_NUM*BANK_RPORT*DATA_W-1:0]   bank_rd_data,
  output logic [RPORT_NUM-1:0]                    rsp_vld,
  output logic [RPORT_NUM*DATA_W-1:0]             rsp_data,
  output logic [RPORT_NUM*TAG_W-1:0]              rsp_tag
);

  localparam int unsigned BANK_W = BANK_X_W + BANK_Y_W;
  localparam int unsigned SLOT_W = clog2_min1(BANK_RPORT);
  localparam int unsigned PTR_W  = clog2_min1(RPORT_NUM);
  localparam int unsigned SEL_W  = clog2_min1(BANK_NUM * BANK_RPORT);

  logic [RPORT_NUM-1:0][ADDR_W-1:0] p_addr;
  logic [RPORT_NUM-1:0][BANK_W-1:0] p_bank;
  logic [RPORT_NUM-1:0][ROW_W-1:0]  p_row;
  logic [RPORT_NUM-1:0][PTR_W-1:0]  p_leader;
  logic [RPORT_NUM-1:0]             is_leader;

  logic [BANK_NUM-1:0][RPORT_NUM-1:0]                  bank_req;
  logic [BANK_NUM-1:0][BANK_RPORT-1:0][RPORT_NUM-1:0]  slot_gnt;
  logic [BANK_NUM-1:0][BANK_RPORT-1:0]                 slot_vld;

  logic [RPORT_NUM-1:0]             lead_gnt, port_gnt;
  logic [RPORT_NUM-1:0][SLOT_W-1:0] lead_slot, port_slot;

  logic [RPORT_NUM-1:0]             vld_q;
  logic                             flush_q;
  logic [RPORT_NUM-1:0][TAG_W-1:0]  tag_q;
  logic [RPORT_NUM-1:0][BANK_W-1:0] bank_q;
  logic [RPORT_NUM-1:0][SLOT_W-1:0] slot_q;

  logic [BANK_NUM*BANK_RPORT-1:0][DATA_W-1:0] rd_data;

  always_comb begin : decode
    logic [REG_W-1:0] reg_idx;
    reg_idx = '0;
    for (int p = 0; p < int'(RPORT_NUM); p++) begin
      p_addr[p] = req_vaddr[p*ADDR_W +: ADDR_W];
      reg_idx   = p_addr[p][ADDR_W-1 -: REG_W];
      p_bank[p] = {reg_idx[REG_W-1 -: BANK_Y_W], p_addr[p][BANK_X_W-1:0]};
      p_row[p]  = reg_idx[ROW_W-1:0];
    end
  end

  // Equal vaddrs share one bank port; the lowest-index valid port leads the group.
  always_comb begin : coalesce
    for (int p = 0; p < int'(RPORT_NUM); p++) begin
      p_leader[p]  = PTR_W'(p);
      is_leader[p] = req_vld[p];
      for (int q = int'(RPORT_NUM) - 1; q >= 0; q--) begin
        if ((q < p) && req_vld[q] && (p_addr[q] == p_addr[p])) begin
          p_leader[p]  = PTR_W'(q);
          is_leader[p] = 1'b0;
        end
      end
    end
  end

  always_comb begin : bank_route
    for (int b = 0; b < int'(BANK_NUM); b++) begin
      for (int p = 0; p < int'(RPORT_NUM); p++) begin
        bank_req[b][p] = is_leader[p] && (p_bank[p] == BANK_W'(b));
      end
    end
  end

  for (genvar b = 0; b < int'(BANK_NUM); b++) begin : g_bank
    rrv64_vec_vrf_bank_rr_arb #(
      .RPORT_NUM  (RPORT_NUM),
      .BANK_RPORT (BANK_RPORT)
    ) u_arb (
      .clk_i      (clk),
      .rst_i      (rst),
      .req_i      (bank_req[b]),
      .slot_gnt_o (slot_gnt[b]),
      .slot_vld_o (slot_vld[b])
    );
  end

  always_comb begin : resolve
    lead_gnt    = '0;
    lead_slot   = '0;
    bank_rd_en  = '0;
    bank_rd_row = '0;
    for (int b = 0; b < int'(BANK_NUM); b++) begin
      for (int s = 0; s < int'(BANK_RPORT); s++) begin
        bank_rd_en[b*BANK_RPORT+s] = slot_vld[b][s];
        for (int p = 0; p < int'(RPORT_NUM); p++) begin
          if (slot_gnt[b][s][p]) begin
            lead_gnt[p]  = 1'b1;
            lead_slot[p] = SLOT_W'(s);
            bank_rd_row[(b*BANK_RPORT+s)*ROW_W +: ROW_W] = p_row[p];
          end
        end
      end
    end
    for (int p = 0; p < int'(RPORT_NUM); p++) begin
      port_gnt[p]  = req_vld[p] & lead_gnt[p_leader[p]];
      port_slot[p] = lead_slot[p_leader[p]];
    end
  end

  assign req_rdy = port_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      flush_q <= 1'b0;
      tag_q   <= '0;
      bank_q  <= '0;
      slot_q  <= '0;
    end else begin
      vld_q   <= port_gnt;
      flush_q <= flush;
      for (int p = 0; p < int'(RPORT_NUM); p++) begin
        if (port_gnt[p]) begin
          tag_q[p]  <= req_tag[p*TAG_W +: TAG_W];
          bank_q[p] <= p_bank[p];
          slot_q[p] <= port_slot[p];
        end
      end
    end
  end

  assign rd_data = bank_rd_data;
  assign rsp_vld = vld_q & ~{RPORT_NUM{flush_q}};

  // Data is zero unless a grant was registered, so reset leaves the outputs clean.
  always_comb begin : rsp_mux
    int sel;
    sel      = 0;
    rsp_data = '0;
    rsp_tag  = '0;
    for (int p = 0; p < int'(RPORT_NUM); p++) begin
      sel = int'(bank_q[p]) * int'(BANK_RPORT) + int'(slot_q[p]);
      rsp_tag[p*TAG_W +: TAG_W] = tag_q[p];
      if (vld_q[p]) rsp_data[p*DATA_W +: DATA_W] = rd_data[SEL_W'(sel)];
    end
  end

endmodule

// File: tb/tb_rrv64_vec_vrf_rd_xbar.sv
// Randomised bench for the VRF read crossbar against a behavioural grant/response model.
module tb_rrv64_vec_vrf_rd_xbar;
  import rrv64_vec_vrf_rd_xbar_pkg::*;

  localparam int NP   = 5;
  localparam int BX   = 1;
  localparam int BY   = 1;
  localparam int RW   = 4;
  localparam int BR   = 2;
  localparam int DW   = 256;
  localparam int TW   = 18;
  localparam int REGW = BY + RW;
  localparam int AW   = REGW + BX;
  localparam int NB   = 1 << (BX + BY);

  logic                   clk = 1'b0;
  logic                   rst, flush;
  logic [NP-1:0]          req_vld, req_rdy, rsp_vld;
  logic [NP*AW-1:0]       req_vaddr;
  logic [NP*TW-1:0]       req_tag, rsp_tag;
  logic [NB*BR-1:0]       bank_rd_en;
  logic [NB*BR*RW-1:0]    bank_rd_row;
  logic [NB*BR*DW-1:0]    bank_rd_data = '0;
  logic [NP*DW-1:0]       rsp_data;

  rrv64_vec_vrf_rd_xbar dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_vld      (req_vld),
    .req_vaddr    (req_vaddr),
    .req_tag      (req_tag),
    .req_rdy      (req_rdy),
    .bank_rd_en   (bank_rd_en),
    .bank_rd_row  (bank_rd_row),
    .bank_rd_data (bank_rd_data),
    .rsp_vld      (rsp_vld),
    .rsp_data     (rsp_data),
    .rsp_tag      (rsp_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  // SRAM content depends on bank, row and the read cycle, so stale or misrouted data shows up.
  function automatic logic [DW-1:0] sram_word(input int b, input int row, input int salt);
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = {8'(b), 8'(row), 4'(k), 12'(salt)};
    return w;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NB * BR; i++) begin
      if (bank_rd_en[i]) bank_rd_data[i*DW +: DW] <= sram_word(i / BR, int'(bank_rd_row[i*RW +: RW]), cyc);
    end
  end

  task automatic check_eq(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  function automatic int bank_of(input logic [AW-1:0] a);
    int v = int'(a);
    return ((v >> (BX + RW)) << BX) | (v & ((1 << BX) - 1));
  endfunction

  function automatic int row_of(input logic [AW-1:0] a);
    return (int'(a) >> BX) & ((1 << RW) - 1);
  endfunction

  function automatic logic [AW-1:0] mk_addr(input int b, input int row);
    return AW'(((b >> BX) << (BX + RW)) | (row << BX) | (b & ((1 << BX) - 1)));
  endfunction

  function automatic logic [TW-1:0] rand_tag();
    vrf_rd_tag_t t;
    t.rs_idx       = 16'(1) << $urandom_range(15);
    t.rs_field_idx = 2'($urandom_range(3));
    return t;
  endfunction

  // Requester state and model state.
  logic [NP-1:0]    vld;
  logic [AW-1:0]    va [NP];
  logic [TW-1:0]    tg [NP];
  int               rr [NB];
  int               rr_n [NB];
  logic [NP-1:0]    gnt, dut_rdy;
  logic [NB*BR-1:0] e_en;
  logic [NB*BR*RW-1:0] e_row;
  logic [NP-1:0]    e_vld_q;
  logic             e_flush_q, e_after_rst, chk_rsp;
  logic [TW-1:0]    e_tag [NP];
  logic [DW-1:0]    e_data [NP];

  task automatic model_grant();
    int leader [NP];
    int cnt, p;
    gnt = '0; e_en = '0; e_row = '0;
    for (int i = 0; i < NP; i++) begin
      leader[i] = -1;
      if (vld[i]) for (int q = 0; q <= i; q++)
        if (leader[i] < 0 && vld[q] && va[q] == va[i]) leader[i] = q;
    end
    for (int b = 0; b < NB; b++) begin
      rr_n[b] = rr[b];
      cnt = 0;
      for (int k = 0; k < NP; k++) begin
        p = (rr[b] + k) % NP;
        if (leader[p] == p && bank_of(va[p]) == b && cnt < BR) begin
          e_en[b*BR+cnt] = 1'b1;
          e_row[(b*BR+cnt)*RW +: RW] = RW'(row_of(va[p]));
          for (int q = 0; q < NP; q++) if (leader[q] == p) gnt[q] = 1'b1;
          cnt++;
          rr_n[b] = (p + 1) % NP;
        end
      end
    end
  endtask

  task automatic step(input logic do_rst, input logic do_flush);
    logic [NP-1:0] exp_rsp;
    @(posedge clk); #1;
    rst = do_rst; flush = do_flush; req_vld = vld;
    for (int p = 0; p < NP; p++) begin
      req_vaddr[p*AW +: AW] = va[p];
      req_tag[p*TW +: TW]   = tg[p];
    end
    model_grant();
    #3;
    check_eq("req_rdy", DW'(req_rdy), DW'(gnt));
    check_eq("bank_rd_en", DW'(bank_rd_en), DW'(e_en));
    check_eq("bank_rd_row", DW'(bank_rd_row), DW'(e_row));
    dut_rdy = req_rdy;
    if (chk_rsp) begin
      exp_rsp = e_vld_q & ~{NP{e_flush_q}};
      check_eq("rsp_vld", DW'(rsp_vld), DW'(exp_rsp));
      for (int p = 0; p < NP; p++) begin
        if (exp_rsp[p] || e_after_rst) begin
          check_eq($sformatf("rsp_data[%0d]", p), rsp_data[p*DW +: DW], e_data[p]);
          check_eq($sformatf("rsp_tag[%0d]", p), DW'(rsp_tag[p*TW +: TW]), DW'(e_tag[p]));
        end
      end
    end
    if (do_rst) begin
      for (int b = 0; b < NB; b++) rr[b] = 0;
      e_vld_q = '0; e_flush_q = 1'b0; e_after_rst = 1'b1; chk_rsp = 1'b1;
      for (int p = 0; p < NP; p++) begin e_tag[p] = '0; e_data[p] = '0; end
    end else begin
      for (int b = 0; b < NB; b++) rr[b] = rr_n[b];
      e_vld_q = gnt; e_flush_q = do_flush; e_after_rst = 1'b0;
      for (int p = 0; p < NP; p++) begin
        if (gnt[p]) begin
          e_tag[p]  = tg[p];
          e_data[p] = sram_word(bank_of(va[p]), row_of(va[p]), cyc);
        end
      end
    end
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] a);
    vld[p] = 1'b1; va[p] = a; tg[p] = rand_tag();
  endtask

  task automatic retire();
    vld = vld & ~gnt;
  endtask

  int wait_cnt [NP];
  int seq [NP];
  logic [AW-1:0] pool [6];

  initial begin
    rst = 1'b1; flush = 1'b0; req_vld = '0; req_vaddr = '0; req_tag = '0;
    vld = '0; chk_rsp = 1'b0; e_after_rst = 1'b0; e_flush_q = 1'b0; e_vld_q = '0;
    for (int p = 0; p < NP; p++) begin va[p] = '0; tg[p] = '0; e_tag[p] = '0; e_data[p] = '0; end
    for (int b = 0; b < NB; b++) rr[b] = 0;

    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Single request: bank 1, row 3.
    set_req(0, 6'b00011_1);
    step(1'b0, 1'b0); retire();
    step(1'b0, 1'b0);

    // Three distinct rows on bank 0: two granted, third stalls then goes.
    for (int p = 0; p < 3; p++) set_req(p, mk_addr(0, p + 1));
    step(1'b0, 1'b0); retire();
    step(1'b0, 1'b0); retire();
    step(1'b0, 1'b0);

    // Coalesced group on one bank port.
    set_req(0, mk_addr(2, 9)); set_req(3, mk_addr(2, 9)); set_req(4, mk_addr(2, 9));
    tg[3] = rand_tag(); tg[4] = rand_tag();
    step(1'b0, 1'b0); retire();
    step(1'b0, 1'b0);

    // Five ports spread over four banks.
    set_req(0, mk_addr(0, 4)); set_req(1, mk_addr(1, 5)); set_req(2, mk_addr(2, 6));
    set_req(3, mk_addr(3, 7)); set_req(4, mk_addr(0, 8));
    step(1'b0, 1'b0); retire();
    step(1'b0, 1'b0);

    // Flushed grant, then an unflushed one.
    set_req(1, mk_addr(3, 2));
    step(1'b0, 1'b1); retire();
    set_req(2, mk_addr(1, 12));
    step(1'b0, 1'b0); retire();
    step(1'b0, 1'b0);

    // Sustained 5-way contention on bank 2 with a mid-run reset.
    for (int p = 0; p < NP; p++) begin seq[p] = 0; wait_cnt[p] = 0; set_req(p, mk_addr(2, p * 3)); end
    for (int k = 0; k < 20; k++) begin
      step(k == 10, 1'b0);
      for (int p = 0; p < NP; p++) begin
        if (dut_rdy[p]) wait_cnt[p] = 0;
        else wait_cnt[p]++;
        if (k == 10) wait_cnt[p] = 0;
        check_eq($sformatf("starve_wait[%0d]", p), DW'(wait_cnt[p] > 2), '0);
      end
      for (int p = 0; p < NP; p++) begin
        if (gnt[p]) begin seq[p] = (seq[p] + 1) % 3; set_req(p, mk_addr(2, p * 3 + seq[p])); end
      end
    end
    vld = '0;
    step(1'b0, 1'b0);

    // Random traffic; ungranted requesters hold their request.
    for (int k = 0; k < 300; k++) begin
      if (k % 50 == 0) for (int i = 0; i < 6; i++) pool[i] = AW'($urandom);
      for (int p = 0; p < NP; p++) begin
        if (!vld[p] && $urandom_range(9) < 7)
          set_req(p, ($urandom_range(1) == 0) ? pool[$urandom_range(5)] : AW'($urandom));
      end
      step($urandom_range(49) == 0, $urandom_range(9) == 0);
      retire();
    end
    vld = '0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
